// File: rtl/idct_final.sv
// Inverse 8x8 DCT: X = (B^T * D * B) >>> SHIFT (rounded), plus LEVEL, clamped to 8 bits.
// Two sequential passes of 64 elements each, eight parallel multiplies per element.
// Pass 1 forms T = B^T * D at full precision; pass 2 forms T * B and emits one pixel per cycle.
module idct_final #(
    parameter int COEF_W = 16,
    parameter int SHIFT  = 24,
    parameter int LEVEL  = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [0:64*COEF_W-1] coef,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [0:511]         pix,
    output logic                 busy
);
    localparam int BW = 12;
    // T = sum of 8 products of BW x COEF_W bits: never truncated
    localparam int TW = COEF_W + BW + 3;
    // S = sum of 8 products of TW x BW bits
    localparam int SW = TW + BW + 3;
    localparam logic signed [SW-1:0] HALF = SW'(64'd1 << (SHIFT - 1));
    localparam logic signed [SW-1:0] LVL  = SW'(LEVEL);
    localparam logic signed [SW-1:0] PMAX = SW'(255);

    // Cosine matrix, B[k][n] = round(4096 * c(k) * cos((2n+1)k*pi/16)), row-major
    localparam logic signed [BW-1:0] B [64] = '{
        12'sd1448,  12'sd1448,  12'sd1448,  12'sd1448,  12'sd1448,  12'sd1448,  12'sd1448,  12'sd1448,
        12'sd2009,  12'sd1703,  12'sd1138,  12'sd400,  -12'sd400,  -12'sd1138, -12'sd1703, -12'sd2009,
        12'sd1892,  12'sd784,  -12'sd784,  -12'sd1892, -12'sd1892, -12'sd784,   12'sd784,   12'sd1892,
        12'sd1703, -12'sd400,  -12'sd2009, -12'sd1138,  12'sd1138,  12'sd2009,  12'sd400,  -12'sd1703,
        12'sd1448, -12'sd1448, -12'sd1448,  12'sd1448,  12'sd1448, -12'sd1448, -12'sd1448,  12'sd1448,
        12'sd1138, -12'sd2009,  12'sd400,   12'sd1703, -12'sd1703, -12'sd400,   12'sd2009, -12'sd1138,
        12'sd784,  -12'sd1892,  12'sd1892, -12'sd784,  -12'sd784,   12'sd1892, -12'sd1892,  12'sd784,
        12'sd400,  -12'sd1138,  12'sd1703, -12'sd2009,  12'sd2009, -12'sd1703,  12'sd1138, -12'sd400
    };

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

    state_t                   state_q;
    logic [5:0]               cnt_q;
    logic                     in_ready_q;
    logic                     out_valid_q;
    logic [0:511]             pix_q;
    logic signed [COEF_W-1:0] d_q [64];
    logic signed [TW-1:0]     t_q [64];

    logic [2:0]               row;
    logic [2:0]               col;
    logic signed [TW-1:0]     t_elem_d;
    logic [7:0]               pix_elem_d;
    logic signed [SW-1:0]     s_acc;
    logic signed [SW-1:0]     s_rnd;
    logic signed [SW-1:0]     v_lvl;

    assign row       = cnt_q[5:3];
    assign col       = cnt_q[2:0];
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign pix       = pix_q;
    assign busy      = (state_q == PASS1) || (state_q == PASS2);

    // Pass 1 element: T[row][col] = sum_k B[k][row] * D[k][col]
    always_comb begin
        t_elem_d = '0;
        for (int k = 0; k < 8; k++) begin
            t_elem_d = t_elem_d + TW'(B[{3'(k), row}]) * TW'(d_q[{3'(k), col}]);
        end
    end

    // Pass 2 element: S = sum_k T[row][k] * B[k][col], round half up, level shift, clamp
    always_comb begin
        s_acc = '0;
        for (int k = 0; k < 8; k++) begin
            s_acc = s_acc + SW'(t_q[{row, 3'(k)}]) * SW'(B[{3'(k), col}]);
        end
        s_rnd = (s_acc + HALF) >>> SHIFT;
        v_lvl = s_rnd + LVL;
        if (v_lvl[SW-1]) begin
            pix_elem_d = 8'd0;
        end else if (v_lvl > PMAX) begin
            pix_elem_d = 8'd255;
        end else begin
            pix_elem_d = v_lvl[7:0];
        end
    end

    // Control FSM plus D/T/pixel storage; one block in flight at a time
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            pix_q       <= '0;
            for (int e = 0; e < 64; e++) begin
                d_q[e] <= '0;
                t_q[e] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        for (int e = 0; e < 64; e++) begin
                            d_q[e] <= coef[e*COEF_W +: COEF_W];
                        end
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= PASS1;
                    end
                end
                PASS1: begin
                    t_q[cnt_q] <= t_elem_d;
                    if (cnt_q == 6'd63) begin
                        cnt_q   <= '0;
                        state_q <= PASS2;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                PASS2: begin
                    pix_q[{cnt_q, 3'b000} +: 8] <= pix_elem_d;
                    if (cnt_q == 6'd63) begin
                        cnt_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                DONE: begin
                    // pix stays as the last block after the handshake
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_idct_final.sv
// Bench for idct_final: driver pushes expected blocks into a scoreboard queue,
// a negedge monitor pops and compares whenever a pixel block is presented.
module tb_idct_final;
    localparam int CW = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [0:64*CW-1] coef;
    logic           out_valid;
    logic           out_ready;
    logic [0:511]   pix;
    logic           busy;

    idct_final #(.COEF_W(CW), .SHIFT(24), .LEVEL(128)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .coef(coef), .out_valid(out_valid), .out_ready(out_ready),
        .pix(pix), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0][7:0] exp;
        logic [63:0][7:0] ramp;
        logic             rt;
        logic [31:0]      acc;
    } item_t;

    item_t sb[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    bm[64];
    int    dblk[64];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    // Cosine matrix straight from its definition
    task automatic init_bm();
        real pi, c;
        pi = 3.14159265358979;
        for (int k = 0; k < 8; k++) begin
            c = (k == 0) ? 1.0 / $sqrt(8.0) : 0.5;
            for (int n = 0; n < 8; n++)
                bm[k*8+n] = int'(4096.0 * c * $cos(real'(2*n+1) * real'(k) * pi / 16.0));
        end
    endtask

    function automatic logic [63:0][7:0] fill(input logic [7:0] v);
        return {64{v}};
    endfunction

    // Reference inverse transform on dblk: (B^T D B + half) >>> 24, +128, clamp
    function automatic logic [63:0][7:0] model();
        longint t[64];
        longint s, v;
        logic [63:0][7:0] r;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                t[i*8+j] = 0;
                for (int k = 0; k < 8; k++)
                    t[i*8+j] += longint'(bm[k*8+i]) * longint'(dblk[k*8+j]);
            end
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                s = 0;
                for (int k = 0; k < 8; k++)
                    s += t[i*8+k] * longint'(bm[k*8+j]);
                v = ((s + (64'sd1 <<< 23)) >>> 24) + 128;
                if (v < 0) v = 0;
                if (v > 255) v = 255;
                r[i*8+j] = 8'(v);
            end
        return r;
    endfunction

    task automatic rand_blk();
        for (int e = 0; e < 64; e++) begin
            if (e == 0) dblk[e] = int'($urandom_range(0, 2047)) - 1024;
            else if ($urandom_range(0, 1) == 1) dblk[e] = int'($urandom_range(0, 256)) - 128;
            else dblk[e] = 0;
        end
    endtask

    task automatic drive_coef();
        for (int e = 0; e < 64; e++) coef[e*CW +: CW] = CW'(dblk[e]);
    endtask

    // Present dblk, wait for acceptance, record the expected response
    task automatic send(input logic [63:0][7:0] exp, input logic rt, input logic [63:0][7:0] ramp);
        item_t it;
        bit ok;
        ok = 0;
        @(posedge clk); #1;
        drive_coef();
        in_valid = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (in_ready) begin
                it.exp = exp; it.rt = rt; it.ramp = ramp; it.acc = 32'(cyc + 1);
                sb.push_back(it);
                ok = 1;
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!ok) begin
            total++; bad++;
            $display("FAIL accept_timeout in_ready never rose");
        end
    endtask

    // Wait for the block, optionally stall out_ready, then check the return to IDLE
    task automatic wait_out(input int hold);
        bit got;
        got = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (out_valid) begin got = 1; break; end
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL out_timeout out_valid never rose");
            return;
        end
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1 out_ready = 1'b1;
            @(negedge clk);
        end
        @(negedge clk);
        chk("post_hs_in_ready", in_ready, 1);
        chk("post_hs_out_valid", out_valid, 0);
    endtask

    task automatic run_block(input int hold, input logic [63:0][7:0] exp, input logic rt,
                             input logic [63:0][7:0] ramp);
        out_ready = (hold == 0);
        send(exp, rt, ramp);
        wait_out(hold);
    endtask

    // Monitor: compare on the first cycle of each presented block, then check stability
    bit               seen = 0;
    logic [0:511]     last;
    item_t            cur;
    initial begin
        int nbad, first, g;
        forever begin
            @(negedge clk);
            if (!reset) begin
                seen = 0;
            end else if (out_valid) begin
                if (!seen) begin
                    seen = 1;
                    last = pix;
                    if (sb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_output no block pending");
                    end else begin
                        cur = sb[0];
                        chk("latency", cyc - int'(cur.acc), 128);
                        nbad = 0; first = -1;
                        for (int e = 0; e < 64; e++)
                            if (pix[e*8 +: 8] !== cur.exp[e]) begin
                                nbad++;
                                if (first < 0) first = e;
                            end
                        total++;
                        if (nbad != 0) begin
                            bad++;
                            $display("FAIL pix_block elem=%0d got=%0d exp=%0d wrong=%0d",
                                     first, pix[first*8 +: 8], cur.exp[first], nbad);
                        end
                        if (cur.rt) begin
                            nbad = 0; first = -1;
                            for (int e = 0; e < 64; e++) begin
                                g = int'(pix[e*8 +: 8]) - int'(cur.ramp[e]);
                                if (g > 1 || g < -1) begin
                                    nbad++;
                                    if (first < 0) first = e;
                                end
                            end
                            total++;
                            if (nbad != 0) begin
                                bad++;
                                $display("FAIL round_trip elem=%0d got=%0d want_near=%0d wrong=%0d",
                                         first, pix[first*8 +: 8], cur.ramp[first], nbad);
                            end
                        end
                    end
                end else begin
                    total++;
                    if (pix !== last) begin
                        bad++;
                        $display("FAIL pix_stable block changed while out_valid held");
                    end
                end
                if (out_ready) begin
                    if (sb.size() > 0) void'(sb.pop_front());
                    seen = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        total++; bad++;
        $display("FAIL watchdog simulation time limit");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        logic [63:0][7:0] a, expa, expb;
        longint y;
        init_bm();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; coef = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pix_nonzero", (pix !== '0), 0);
        @(negedge clk); reset = 1'b1;

        // all-zero block
        for (int e = 0; e < 64; e++) dblk[e] = 0;
        run_block(0, fill(8'd128), 0, '0);
        // DC-only and clamp cases
        dblk[0] = 80;    run_block(1, fill(8'd138), 0, '0);
        dblk[0] = 2000;  run_block(0, fill(8'd255), 0, '0);
        dblk[0] = -2000; run_block(2, fill(8'd0), 0, '0);

        // round trip of a ramp through a forward DCT
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) a[i*8+j] = 8'(16*i + j);
        for (int u = 0; u < 8; u++)
            for (int v = 0; v < 8; v++) begin
                y = 0;
                for (int m = 0; m < 8; m++)
                    for (int n = 0; n < 8; n++)
                        y += longint'(bm[u*8+m]) * (longint'(a[m*8+n]) - 128) * longint'(bm[v*8+n]);
                dblk[u*8+v] = int'((y + (64'sd1 <<< 23)) >>> 24);
            end
        run_block(0, model(), 1, a);

        // random blocks with random output stalls
        for (int r = 0; r < 4; r++) begin
            rand_blk();
            run_block(int'($urandom_range(0, 3)), model(), 0, '0);
        end

        // backpressure: hold out_ready low, a second block waits
        out_ready = 1'b0;
        rand_blk(); expa = model();
        send(expa, 0, '0);
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk("bp_out_valid", out_valid, 1);
        rand_blk(); expb = model();
        @(posedge clk); #1;
        drive_coef();
        in_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("bp_hold_ready_valid_busy", {in_ready, out_valid, busy}, 3'b010);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        send(expb, 0, '0);
        wait_out(0);

        // reset in the middle of pass 1
        out_ready = 1'b1;
        rand_blk();
        send(model(), 0, '0);
        repeat (30) @(posedge clk);
        #1;
        chk("mid_busy", busy, 1);
        reset = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_pix_nonzero", (pix !== '0), 0);
        sb.delete();
        @(negedge clk); reset = 1'b1;
        for (int e = 0; e < 64; e++) dblk[e] = 0;
        dblk[0] = 80;
        run_block(0, fill(8'd138), 0, '0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/idct_final.md
Name: idct_final

Overview:
- Inverse 2-D 8x8 DCT. Complement of the forward DCT block, using the same 12-bit cosine matrix B (B = round(4096*C), rows as in the forward DCT).
- Accepts one 8x8 block of signed coefficients and computes X = (B^T * D * B) >>> 24 with rounding.
- Adds the +128 level shift back and clamps the result to 8-bit pixels.
- Sits between the coefficient store / approximate-multiplier datapath and the pixel reconstruction buffer. Uses a valid/ready handshake on both sides.

Parameters:
- COEF_W, 16, signed coefficient width per element.
- SHIFT, 24, final right-shift (2 x 12 fractional bits of B).
- LEVEL, 128, level shift added after the transform.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- in_valid  in  1  coefficient block present on coef.
- in_ready  out  1  block can be accepted.
- coef  in  [0:64*COEF_W-1]  signed D[i][j] at bits (i*8+j)*COEF_W +: COEF_W, row-major.
- out_valid  out  1  pixel block valid.
- out_ready  in  1  consumer accepts the pixel block.
- pix  out  [0:511]  unsigned X[i][j] at bits (i*8+j)*8 +: 8, row-major.
- busy  out  1  high in PASS1 or PASS2.

Behaviour:
- Reset values (asserted asynchronously): state=IDLE, in_ready=1, out_valid=0, busy=0, pix=0, cnt=0, internal D/T registers 0.
- B is a constant 8x8 array of signed 12-bit values: 1448, ±2009, ±1703, ±1138, ±400, ±1892, ±784, identical to the forward DCT.
- FSM states:
  - IDLE: in_ready=1. On an edge with in_valid&&in_ready, latch all 64 coef into D, set cnt=0, go to PASS1, in_ready<=0. coef is sampled only on this edge.
  - PASS1: each edge computes one element T[i][j] = sum over k=0..7 of B[k][i]*D[k][j], with i=cnt[5:3] and j=cnt[2:0]. Eight parallel multiplies.
    - T is kept at full precision, 31-bit signed, with no truncation.
    - After cnt=63, set cnt=0 and go to PASS2.
  - PASS2: each edge computes S = sum over k=0..7 of T[i][k]*B[k][j], using a 46-bit signed accumulator minimum.
    - v = ((S + 2^(SHIFT-1)) >>> SHIFT) + LEVEL.
    - pix[i][j] = 0 if v<0, 255 if v>255, else v.
    - After cnt=63: out_valid<=1, go to DONE.
  - DONE: pix and out_valid held stable. On an edge with out_valid&&out_ready: out_valid<=0, in_ready<=1, go to IDLE. pix keeps its last value.
- Latency: the accept edge is edge 0. PASS1 uses edges 1..64 and PASS2 edges 65..128. out_valid is high after edge 128.
- Throughput: one block per 129 cycles plus handshake cycles. There is no overlap between blocks: in_ready=0 from acceptance until the DONE handshake completes.
- in_valid while in_ready=0 is ignored. The producer holds coef until it is accepted.
- out_ready high while out_valid=0 has no effect.
- busy = (state==PASS1 || state==PASS2).
- Rounding is arithmetic: add half, then arithmetic shift (floor). Negative ties round toward +inf.
- Reset asserted mid-PASS1/PASS2/DONE aborts immediately to reset values. The partial block is discarded and no out_valid pulse is produced.

Test Plan:
- All-zero coef, out_ready=1 -> out_valid after exactly 128 cycles from the accept edge; all 64 pix=128; in_ready back to 1 the cycle after the handshake.
- DC only, D[0][0]=80, rest 0 -> S=167736320, v=10+128 -> all pix=138.
- Clamp: D[0][0]=2000 -> all pix=255. D[0][0]=-2000 -> v=-250+128 -> all pix=0.
- Round trip: drive a ramp block A[i][j]=16*i+j through the forward DCT and feed its outputs as coef -> every pix within ±1 of A[i][j].
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> pix and out_valid stable, in_ready=0, a second in_valid is not accepted. Raise out_ready -> handshake completes, then the second block is accepted.
- Reset: drop reset at PASS1 cnt=30 -> out_valid=0, in_ready=1, busy=0, pix=0 immediately. A new DC block then completes normally with correct values.
